hazard_fwd_unit: RTL and testbench

- Parametrised successor to the pipeline's stall-only hazard unit: keeps its own scoreboard of in-flight writebacks (EX..WB), produces operand-forwarding selects, load-use stalls and multi-cycle-op stalls.
- Sits beside the ID stage. Drives the IF/ID freeze, bubble insertion into ID/EX, and the EX operand muxes.
- Mode input selects legacy stall-only behaviour or forwarding behaviour.

---
 rtl/hazard_fwd_unit_pkg.sv | 14 +
 rtl/hazard_fwd_match.sv | 32 +++
 rtl/hazard_fwd_unit.sv | 60 ++++++
 tb/tb_hazard_fwd_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg: shared slot type, forwarding constants and select-width helper.
package hazard_fwd_unit_pkg;
   localparam int DEST_MAX = 8;
   localparam int FWD_RF = 0;
   typedef struct packed {
      logic valid;
      logic wbEn;
      logic [DEST_MAX-1:0] dest;
      logic memRead;
   } slot_t;
   function automatic int selWidth(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/hazard_fwd_match.sv
// hazard_fwd_match: priority matcher of one source register against the in-flight slots.
module hazard_fwd_match
   import hazard_fwd_unit_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int REG_W = 4,
   parameter int LOAD_LAT = 1,
   parameter int SEL_W = selWidth(DEPTH)
) (
   input  slot_t            slots [DEPTH],
   input  logic [REG_W-1:0] src,
   input  logic             srcEn,
   input  logic             fwdEn,
   output logic [SEL_W-1:0] sel,
   output logic             hazard
);
   logic found;
   // Youngest producer wins; in legacy mode the WB slot is covered by the write-first register file.
   always_comb begin
      sel = SEL_W'(FWD_RF);
      hazard = 1'b0;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!found && srcEn && slots[i].valid && slots[i].wbEn && slots[i].dest == DEST_MAX'(src)) begin
            found = 1'b1;
            if (!fwdEn) hazard = (i < DEPTH - 1);
            else if (slots[i].memRead && i < LOAD_LAT) hazard = 1'b1;
            else sel = SEL_W'(i + 1);
         end
      end
   end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: in-flight writeback scoreboard driving forwarding selects, load-use and multi-cycle stalls.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter int REG_W = 4,
   parameter int DEPTH = 3,
   parameter int LOAD_LAT = 1,
   parameter int MULTI_LAT = 4,
   parameter int SEL_W = selWidth(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fwd_en,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_two_src,
   input  logic             id_wb_en,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_mem_read,
   input  logic             id_multi,
   input  logic             flush,
   output logic             stall,
   output logic [SEL_W-1:0] fwd_sel_a,
   output logic [SEL_W-1:0] fwd_sel_b,
   output logic             ex_busy,
   output logic [31:0]      stall_cycles
);
   localparam int CNT_W = $clog2(MULTI_LAT + 1);
   slot_t slotQ [DEPTH];
   slot_t idSlot;
   logic [CNT_W-1:0] busyCnt;
   logic hazA, hazB, accept;

   hazard_fwd_match #(.DEPTH(DEPTH), .REG_W(REG_W), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) matchA (
      .slots(slotQ), .src(id_rn), .srcEn(1'b1), .fwdEn(fwd_en), .sel(fwd_sel_a), .hazard(hazA)
   );
   hazard_fwd_match #(.DEPTH(DEPTH), .REG_W(REG_W), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) matchB (
      .slots(slotQ), .src(id_rm), .srcEn(id_two_src), .fwdEn(fwd_en), .sel(fwd_sel_b), .hazard(hazB)
   );

   assign idSlot = '{valid: 1'b1, wbEn: id_wb_en, dest: DEST_MAX'(id_dest), memRead: id_mem_read};
   assign ex_busy = busyCnt != '0;
   assign stall = hazA | hazB | ex_busy;
   assign accept = id_valid & ~stall & ~flush;

   // While busy the multi-cycle op stays in EX and bubbles drain into the next slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) slotQ[i] <= '0;
         busyCnt <= '0;
         stall_cycles <= '0;
      end else begin
         slotQ[0] <= ex_busy ? slotQ[0] : accept ? idSlot : '0;
         for (int i = 1; i < DEPTH; i++) slotQ[i] <= (ex_busy && i == 1) ? '0 : slotQ[i-1];
         busyCnt <= ex_busy ? busyCnt - 1'b1 : (accept && id_multi) ? CNT_W'(MULTI_LAT - 1) : '0;
         if (stall && ~&stall_cycles) stall_cycles <= stall_cycles + 32'd1;
      end
   end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed and random checks of hazard_fwd_unit against a pipeline-level model.
module tb_hazard_fwd_unit;
   localparam int DEPTH = 3;
   localparam int LOAD_LAT = 1;
   localparam int MULTI_LAT = 4;

   logic clk = 1'b0, rst = 1'b0, fwd_en = 1'b0, id_valid = 1'b0, id_two_src = 1'b0;
   logic id_wb_en = 1'b0, id_mem_read = 1'b0, id_multi = 1'b0, flush = 1'b0;
   logic [3:0] id_rn = '0, id_rm = '0, id_dest = '0;
   logic stall, ex_busy;
   logic [1:0] fwd_sel_a, fwd_sel_b;
   logic [31:0] stall_cycles;

   int total = 0, bad = 0;

   typedef struct {
      bit v;
      bit w;
      int d;
      bit ld;
   } instr_t;
   instr_t pipe [DEPTH];
   int busyLeft = 0;
   longint stalls = 0;
   bit eStall;
   int eSelA, eSelB;

   hazard_fwd_unit dut (
      .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
      .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_read(id_mem_read),
      .id_multi(id_multi), .flush(flush), .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .ex_busy(ex_busy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int youngest(input int r, input bit live);
      for (int k = 0; k < DEPTH; k++)
         if (live && pipe[k].v && pipe[k].w && pipe[k].d == r) return k;
      return -1;
   endfunction

   // Hazard decision for one source: stage index of the youngest in-flight producer.
   task automatic judge(input int y, output bit hz, output int sel);
      hz = 0;
      sel = 0;
      if (y < 0) return;
      if (!fwd_en) hz = (y <= DEPTH - 2);
      else if (pipe[y].ld && y < LOAD_LAT) hz = 1;
      else sel = y + 1;
   endtask

   task automatic drive(input bit v, input int rn, input int rm, input bit two, input bit wb,
                        input int dst, input bit ld, input bit mul, input bit fl);
      id_valid = v; id_rn = 4'(rn); id_rm = 4'(rm); id_two_src = two; id_wb_en = wb;
      id_dest = 4'(dst); id_mem_read = ld; id_multi = mul; flush = fl;
   endtask

   task automatic look(input string tag);
      bit hA, hB;
      @(negedge clk);
      judge(youngest(int'(id_rn), 1'b1), hA, eSelA);
      judge(youngest(int'(id_rm), id_two_src), hB, eSelB);
      eStall = hA || hB || busyLeft > 0;
      chk({tag, ".stall"}, 64'(stall), 64'(eStall));
      chk({tag, ".sel_a"}, 64'(fwd_sel_a), 64'(eSelA));
      chk({tag, ".sel_b"}, 64'(fwd_sel_b), 64'(eSelB));
      chk({tag, ".ex_busy"}, 64'(ex_busy), 64'(busyLeft > 0));
      chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(stalls));
   endtask

   task automatic tick();
      bit acc;
      instr_t fresh;
      @(posedge clk);
      acc = id_valid && !eStall && !flush;
      fresh = '{v: acc, w: id_wb_en, d: int'(id_dest), ld: id_mem_read};
      if (eStall && stalls < 64'hFFFF_FFFF) stalls++;
      for (int k = DEPTH - 1; k >= 1; k--) pipe[k] = pipe[k-1];
      if (busyLeft > 0) begin
         pipe[1] = '{v: 0, w: 0, d: 0, ld: 0};
         busyLeft--;
      end else begin
         pipe[0] = fresh;
         busyLeft = (acc && id_multi) ? MULTI_LAT - 1 : 0;
      end
      #1;
   endtask

   task automatic step(input string tag);
      look(tag);
      tick();
   endtask

   task automatic clearModel();
      for (int k = 0; k < DEPTH; k++) pipe[k] = '{v: 0, w: 0, d: 0, ld: 0};
      busyLeft = 0;
      stalls = 0;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < n; k++) step("idle");
   endtask

   initial begin
      longint base;
      clearModel();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.stall", 64'(stall), 0);
      chk("rst.ex_busy", 64'(ex_busy), 0);
      chk("rst.stall_cycles", 64'(stall_cycles), 0);
      rst = 1'b1;

      // Legacy: ADD R1 then ADD R2,R1
      fwd_en = 0;
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0); step("leg.add1");
      drive(1, 1, 0, 0, 1, 2, 0, 0, 0);
      look("leg.dep0"); chk("leg.c1", 64'(stall), 1); tick();
      look("leg.dep1"); chk("leg.c2", 64'(stall), 1); chk("leg.sel", 64'(fwd_sel_a), 0); tick();
      look("leg.dep2"); chk("leg.c3", 64'(stall), 0); tick();
      idle(3);

      // Forwarding: same pair
      fwd_en = 1;
      base = stalls;
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0); step("fwd.add1");
      drive(1, 1, 0, 0, 1, 2, 0, 0, 0);
      look("fwd.dep"); chk("fwd.stall", 64'(stall), 0); chk("fwd.sel_a1", 64'(fwd_sel_a), 1); tick();
      chk("fwd.nostall", 64'(stall_cycles), 64'(base));
      idle(3);

      // Load-use
      base = stalls;
      drive(1, 0, 0, 0, 1, 3, 1, 0, 0); step("lu.ldr");
      drive(1, 0, 3, 1, 1, 4, 0, 0, 0);
      look("lu.c1"); chk("lu.stall", 64'(stall), 1); chk("lu.selb0", 64'(fwd_sel_b), 0); tick();
      look("lu.c2"); chk("lu.go", 64'(stall), 0); chk("lu.selb2", 64'(fwd_sel_b), 2); tick();
      chk("lu.count", 64'(stall_cycles), 64'(base + 1));
      idle(3);

      // Youngest wins; Rm ignored without two_src
      drive(1, 0, 0, 0, 1, 5, 0, 0, 0); step("yw.r5a");
      drive(1, 0, 0, 0, 0, 9, 0, 0, 0); step("yw.nop");
      drive(1, 0, 0, 0, 1, 5, 0, 0, 0); step("yw.r5b");
      drive(1, 5, 5, 0, 1, 6, 0, 0, 0);
      look("yw.use"); chk("yw.sel_a", 64'(fwd_sel_a), 1); chk("yw.sel_b", 64'(fwd_sel_b), 0); tick();
      idle(3);

      // Sort occupies EX
      drive(1, 0, 0, 0, 1, 7, 0, 1, 0); step("sort.go");
      drive(1, 0, 0, 0, 1, 8, 0, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         look("sort.busy"); chk("sort.stall", 64'(stall), 1); chk("sort.busy1", 64'(ex_busy), 1); tick();
      end
      look("sort.next"); chk("sort.accept", 64'(stall), 0); chk("sort.idle", 64'(ex_busy), 0); tick();
      idle(3);

      // Flush kills the ID instruction
      drive(1, 0, 0, 0, 1, 2, 0, 0, 1); step("fl.kill");
      drive(1, 2, 0, 0, 1, 3, 0, 0, 0);
      look("fl.after"); chk("fl.sel", 64'(fwd_sel_a), 0); tick();
      idle(3);

      // Async reset mid-sort
      drive(1, 0, 0, 0, 1, 7, 0, 1, 0); step("rs.sort");
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0); step("rs.busy");
      rst = 1'b0;
      #1;
      chk("rs.stall", 64'(stall), 0);
      chk("rs.ex_busy", 64'(ex_busy), 0);
      chk("rs.sel_a", 64'(fwd_sel_a), 0);
      chk("rs.sel_b", 64'(fwd_sel_b), 0);
      chk("rs.count", 64'(stall_cycles), 0);
      clearModel();
      rst = 1'b1;
      look("rs.first"); chk("rs.accept", 64'(stall), 0); tick();
      idle(2);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 19) == 0) fwd_en = ~fwd_en;
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0, busyLeft == 0 && $urandom_range(0, 9) == 0);
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
